// File: rtl/m_queue_arbiter_pkg.sv
// m_queue_arbiter_pkg
//   Shared definitions for the queue arbiter slice: default data width,
//   hold counter width and the drain FSM state encoding.
package m_queue_arbiter_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } drain_state_e;

endpackage

// File: rtl/m_rr_arb2.sv
// m_rr_arb2
//   Two-way strict round-robin push arbiter with its last-grant register.
//   Ports:
//     clk_i, rst_ni   clock, asynchronous active-low reset
//     req0_i, req1_i  producer requests
//     full_i          queue full; suppresses all grants
//     gnt0_o, gnt1_o  combinational grants (one-hot or zero)
module m_rr_arb2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req0_i,
    input  logic req1_i,
    input  logic full_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    // Index of the requester granted most recently (1 after reset so that
    // requester 0 wins the first tie).
    logic last_gnt_q, last_gnt_d;

    always_comb begin
        gnt0_o     = 1'b0;
        gnt1_o     = 1'b0;
        last_gnt_d = last_gnt_q;
        if (rst_ni && !full_i) begin
            if (req0_i && req1_i) begin
                gnt0_o = last_gnt_q;
                gnt1_o = !last_gnt_q;
            end else begin
                gnt0_o = req0_i;
                gnt1_o = req1_i;
            end
        end
        if (gnt0_o) begin
            last_gnt_d = 1'b0;
        end else if (gnt1_o) begin
            last_gnt_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/m_queue_arbiter.sv
// m_queue_arbiter
//   Arbitrates two producers onto the push side of an external FWFT queue
//   and drains that queue to a display, holding each entry HOLD_CYCLES
//   cycles before the next pop.
//   Ports:
//     clk, rst_n             clock, asynchronous active-low reset
//     req0/1, data0/1        producer requests and data
//     gnt0/1                 same-cycle push acknowledges
//     q_push, q_wdata        queue push side
//     q_full                 queue full flag
//     q_pop, q_rdata         queue pop side (FWFT data)
//     q_empty                queue empty flag
//     disp_en                enables draining to the display
//     disp_data, disp_valid  registered display outputs
module m_queue_arbiter
    import m_queue_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              q_push,
    output logic [DATA_W-1:0] q_wdata,
    input  logic              q_full,
    output logic              q_pop,
    input  logic [DATA_W-1:0] q_rdata,
    input  logic              q_empty,
    input  logic              disp_en,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    drain_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic              disp_valid_q, disp_valid_d;

    // Push side
    m_rr_arb2 u_arb (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .req0_i (req0),
        .req1_i (req1),
        .full_i (q_full),
        .gnt0_o (gnt0),
        .gnt1_o (gnt1)
    );

    always_comb begin
        q_push  = gnt0 | gnt1;
        q_wdata = '0;
        if (gnt0) begin
            q_wdata = data0;
        end else if (gnt1) begin
            q_wdata = data1;
        end
    end

    // Drain side
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;
        q_pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (disp_en && !q_empty) begin
                    q_pop        = rst_n;
                    state_d      = HOLD;
                    cnt_d        = HOLD_LOAD;
                    disp_data_d  = q_rdata;
                    disp_valid_d = 1'b1;
                end
            end
            HOLD: begin
                // The cycle that reads zero is the last HOLD cycle.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
        end
    end

    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_m_queue_arbiter.sv
// tb_m_queue_arbiter
//   Scoreboard bench: the stimulus task drives the DUT and an external FWFT
//   queue, and a reference model pushes expected grants/pops into queues;
//   a negedge monitor pops and compares whenever the DUT acts.
module tb_m_queue_arbiter;

    localparam int DW    = 8;
    localparam int HOLD  = 4;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic          idx;
        logic [DW-1:0] data;
    } push_t;

    logic clk = 1'b0;
    logic rst_n, req0, req1, gnt0, gnt1, q_push, q_full, q_pop, q_empty;
    logic disp_en, disp_valid;
    logic [DW-1:0] data0, data1, q_wdata, q_rdata, disp_data;

    always #5 clk = ~clk;

    m_queue_arbiter #(.DATA_W(DW), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
        .q_push(q_push), .q_wdata(q_wdata), .q_full(q_full),
        .q_pop(q_pop), .q_rdata(q_rdata), .q_empty(q_empty),
        .disp_en(disp_en), .disp_data(disp_data), .disp_valid(disp_valid)
    );

    push_t         exp_push[$];
    logic [DW-1:0] exp_pop[$];
    logic [DW-1:0] env_q[$];
    logic [DW-1:0] mdl_q[$];
    int            cyc, m_next_pop, n_vec, n_err;
    bit            m_last;
    logic          s_push, s_pop;
    logic [DW-1:0] s_wdata, exp_disp;
    logic          exp_dvalid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: update the external queue from last cycle's DUT activity,
    // drive new inputs, and let the model queue its expectations.
    task automatic step(input bit rv, input bit r0, input bit r1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input bit ff, input bit den);
        bit    full_in;
        push_t e;
        @(posedge clk);
        cyc++;
        if (s_push) env_q.push_back(s_wdata);
        if (s_pop && env_q.size() > 0) env_q.delete(0);
        #1;
        rst_n   = rv;
        req0    = r0;
        req1    = r1;
        data0   = d0;
        data1   = d1;
        disp_en = den;
        full_in = ff || (env_q.size() >= DEPTH);
        q_full  = full_in;
        q_empty = (env_q.size() == 0);
        q_rdata = (env_q.size() > 0) ? env_q[0] : '0;
        if (!rv) begin
            m_last     = 1'b1;
            m_next_pop = 0;
            exp_push.delete();
            exp_pop.delete();
        end else begin
            // A display may take a new entry no sooner than HOLD+1 cycles
            // after the previous one; pop uses the queue head before any push.
            if (den && mdl_q.size() > 0 && cyc >= m_next_pop) begin
                exp_pop.push_back(mdl_q[0]);
                mdl_q.delete(0);
                m_next_pop = cyc + HOLD + 1;
            end
            if (!full_in && (r0 || r1)) begin
                if (r0 && r1) e.idx = ~m_last;
                else          e.idx = r1;
                e.data = e.idx ? d1 : d0;
                m_last = e.idx;
                exp_push.push_back(e);
                mdl_q.push_back(e.data);
            end
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        push_t         e;
        logic [DW-1:0] p;
        s_push  = q_push;
        s_wdata = q_wdata;
        s_pop   = q_pop;
        if (!rst_n) begin
            exp_disp   = '0;
            exp_dvalid = 1'b0;
            exp_push.delete();
            exp_pop.delete();
        end else begin
            chk("gnt_onehot", 32'({gnt0 & gnt1, q_push ^ (gnt0 | gnt1)}), 32'd0);
            if (q_push || exp_push.size() > 0) begin
                if (exp_push.size() == 0) begin
                    chk("unexpected_push", 32'(q_push), 32'd0);
                end else begin
                    e = exp_push.pop_front();
                    chk("push", 32'({q_push, gnt1, q_wdata}), 32'({1'b1, e.idx, e.data}));
                end
            end
            chk("disp", 32'({disp_valid, disp_data}), 32'({exp_dvalid, exp_disp}));
            if (q_pop || exp_pop.size() > 0) begin
                if (exp_pop.size() == 0) begin
                    chk("unexpected_pop", 32'(q_pop), 32'd0);
                end else begin
                    p = exp_pop.pop_front();
                    chk("pop", 32'(q_pop), 32'd1);
                    exp_disp   = p;
                    exp_dvalid = 1'b1;
                end
            end
        end
    end

    int pops[$];

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        q_full = 1'b0; q_empty = 1'b1; q_rdata = '0; disp_en = 1'b0;
        s_push = 1'b0; s_pop = 1'b0; s_wdata = '0;
        exp_disp = '0; exp_dvalid = 1'b0;
        m_last = 1'b1; m_next_pop = 0; cyc = 0; n_vec = 0; n_err = 0;

        // Reset: everything quiet even with both requests up
        repeat (2) begin
            step(0, 1, 1, 8'h5A, 8'h6B, 0, 1);
            #1 chk("reset_outs", 32'({gnt0, gnt1, q_push, q_pop, disp_valid, disp_data}), 32'd0);
        end

        // Tie alternates starting with requester 0
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 1, 8'hA1, 8'hB2, 0, 0);
            #1 chk("rr_alt", 32'({gnt0, gnt1, q_wdata}),
                   (i % 2 == 1) ? 32'({2'b01, 8'hB2}) : 32'({2'b10, 8'hA1}));
        end
        repeat (25) step(1, 0, 0, '0, '0, 0, 1);

        // Full blocks grants; release grants in the same cycle
        repeat (3) begin
            step(1, 1, 0, 8'hC3, '0, 1, 0);
            #1 chk("full_block", 32'({gnt0, q_push}), 32'd0);
        end
        step(1, 1, 0, 8'hC3, '0, 0, 0);
        #1 chk("full_release", 32'({gnt0, q_push}), 32'b11);
        repeat (8) step(1, 0, 0, '0, '0, 0, 1);

        // Drain cadence
        step(1, 1, 0, 8'h11, '0, 0, 0);
        step(1, 1, 0, 8'h22, '0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0, '0, '0, 0, 1);
            #1 if (q_pop) pops.push_back(cyc);
        end
        chk("drain_pops", 32'(pops.size()), 32'd2);
        if (pops.size() == 2) chk("drain_gap", 32'(pops[1] - pops[0]), 32'(HOLD + 1));

        // disp_en dropped two cycles into HOLD
        step(1, 1, 0, 8'h33, '0, 0, 0);
        step(1, 1, 0, 8'h44, '0, 0, 0);
        step(1, 1, 0, 8'h55, '0, 0, 0);
        step(1, 0, 0, '0, '0, 0, 1);
        #1 chk("en_drop_pop", 32'(q_pop), 32'd1);
        repeat (2) step(1, 0, 0, '0, '0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, '0, '0, 0, 0);
            #1 chk("en_drop_nopop", 32'(q_pop), 32'd0);
        end
        chk("en_drop_disp", 32'(disp_data), 32'h33);
        repeat (15) step(1, 0, 0, '0, '0, 0, 1);

        // Reset mid-HOLD; last pre-reset grant goes to requester 0
        step(1, 0, 1, '0, 8'h66, 0, 0);
        step(1, 1, 0, 8'h77, '0, 0, 0);
        step(1, 0, 0, '0, '0, 0, 1);
        step(1, 0, 0, '0, '0, 0, 1);
        step(0, 1, 1, 8'h88, 8'h99, 0, 1);
        #1 chk("rst_mid_hold", 32'({q_pop, q_push, disp_valid, disp_data}), 32'd0);
        step(1, 1, 1, 8'h88, 8'h99, 0, 0);
        #1 chk("rst_tie_req0", 32'({gnt0, gnt1, q_wdata}), 32'({2'b10, 8'h88}));
        repeat (15) step(1, 0, 0, '0, '0, 0, 1);

        // Push and pop in the same cycle
        step(1, 1, 0, 8'hAA, '0, 0, 0);
        step(1, 0, 1, '0, 8'hBB, 0, 1);
        #1 chk("push_pop_same", 32'({q_push, q_pop}), 32'b11);
        step(1, 0, 0, '0, '0, 0, 0);
        chk("occupancy", 32'(env_q.size()), 32'd1);
        repeat (8) step(1, 0, 0, '0, '0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 3) != 0));
        end
        repeat (60) step(1, 0, 0, '0, '0, 0, 1);
        chk("final_occupancy", 32'(env_q.size()), 32'(mdl_q.size()));

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
